flopenr_bist: RTL

Synthesizable built-in self-test engine that drives and checks the enabled, resettable register used throughout the MIPS datapath. It plays the stimulus/checker end of the register interface. It generates pseudo-random en/d/reset vectors, drives them into a register under test, and samples the register's q one cycle later. It compares q against an internal golden model, counts mismatches, and reports pass/fail. It sits beside the datapath as a hardware replacement for vector-file benches.

---
 rtl/flopenr_bist.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/flopenr_bist.sv
`default_nettype none
// ============================================================================
//  Module   : flopenr_bist
//  Purpose  : Built-in self-test engine for an enabled, resettable register
//             (flopenr). Generates LFSR-driven en/d/reset vectors and drives
//             them into the register under test. Checks the register's q one
//             cycle later against an internal golden model. Counts mismatches
//             with saturation and reports pass/fail when the run completes.
//  Ports    :
//    clk        in   clock
//    rst        in   synchronous, active-low reset
//    start      in   one-cycle pulse, starts a run from IDLE or DONE
//    dut_rst    out  active-high reset to the register under test
//    dut_en     out  enable to the register under test
//    dut_d      out  [WIDTH] data to the register under test
//    dut_q      in   [WIDTH] output of the register under test
//    busy       out  high while vectors are applied or checked
//    done       out  high from run completion until next start or reset
//    pass       out  valid with done; 1 when no mismatch was seen
//    err_count  out  [ERRW] saturating mismatch count
//    vec_index  out  [clog2(NUM_VECTORS)] index of the vector being driven
//  Revision : 1.0 - initial release
// ============================================================================
module flopenr_bist #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned NUM_VECTORS = 16,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned RST_AT      = 7,
  parameter int unsigned ERRW        = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           dut_rst,
  output logic                           dut_en,
  output logic [WIDTH-1:0]               dut_d,
  input  logic [WIDTH-1:0]               dut_q,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [ERRW-1:0]                err_count,
  output logic [$clog2(NUM_VECTORS)-1:0] vec_index
);

  localparam int unsigned IDXW = $clog2(NUM_VECTORS);

  // A zero seed would lock the LFSR at zero, so it is replaced.
  localparam logic [15:0]     SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] model_q, model_d;
  logic             dut_rst_q, dut_rst_d;
  logic             dut_en_q, dut_en_d;
  logic [WIDTH-1:0] dut_d_q, dut_d_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERRW-1:0]  err_q, err_d;

  logic             w_mismatch;
  logic [ERRW-1:0]  w_err_inc;

  // Written so that an unknown equality result falls through to the
  // mismatch default: X/Z on dut_q is treated as a failure.
  always_comb begin
    w_mismatch = 1'b1;
    if (dut_q == model_q) begin
      w_mismatch = 1'b0;
    end
  end

  assign w_err_inc = (&err_q) ? err_q : err_q + ERRW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED_EFF;
      idx_q     <= '0;
      model_q   <= '0;
      dut_rst_q <= 1'b0;
      dut_en_q  <= 1'b0;
      dut_d_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      idx_q     <= idx_d;
      model_q   <= model_d;
      dut_rst_q <= dut_rst_d;
      dut_en_q  <= dut_en_d;
      dut_d_q   <= dut_d_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    idx_d     = idx_q;
    model_d   = model_q;
    dut_rst_d = dut_rst_q;
    dut_en_d  = dut_en_q;
    dut_d_d   = dut_d_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Every run replays the same sequence from the seed.
          state_d   = S_APPLY;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = '0;
          idx_d     = '0;
          dut_rst_d = 1'b1;
          dut_en_d  = SEED_EFF[0];
          dut_d_d   = SEED_EFF[WIDTH:1];
          lfsr_d    = lfsr_next(SEED_EFF);
        end
      end

      S_APPLY: begin
        // dut_q now reflects the vector applied in the previous cycle, which
        // model_q also holds; vector 0 has no predecessor to check.
        if ((idx_q != '0) && w_mismatch) begin
          err_d = w_err_inc;
        end

        // Model captures the currently driven vector on the same edge as
        // the register under test.
        if (dut_rst_q) begin
          model_d = '0;
        end else if (dut_en_q) begin
          model_d = dut_d_q;
        end

        if (idx_q != LAST_IDX) begin
          idx_d     = idx_q + IDXW'(1);
          dut_rst_d = ((32'(idx_q) + 32'd1) == RST_AT);
          dut_en_d  = lfsr_q[0];
          dut_d_d   = lfsr_q[WIDTH:1];
          lfsr_d    = lfsr_next(lfsr_q);
        end else begin
          // dut_d is held; with en and rst low the register keeps its value.
          state_d   = S_DRAIN;
          dut_rst_d = 1'b0;
          dut_en_d  = 1'b0;
        end
      end

      S_DRAIN: begin
        // Last vector's result; pass must include this compare.
        if (w_mismatch) begin
          err_d = w_err_inc;
        end
        pass_d  = (err_q == '0) && !w_mismatch;
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dut_rst   = dut_rst_q;
  assign dut_en    = dut_en_q;
  assign dut_d     = dut_d_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign vec_index = idx_q;

endmodule
`default_nettype wire
